// File: rtl/lcd_text_sequencer.sv
// LCD text sequencer: sends init commands plus a 2x16 character buffer to an LCD byte controller.
// Optional macro LCD_AUTO_REFRESH_EN makes every accepted buffer write request a redraw.
module lcd_text_sequencer #(
    parameter int DLY_CYCLES = 262142,
    parameter int NUM_LINES  = 2,
    parameter int COLS       = 16
) (
    input  logic       iCLK,
    input  logic       iRST_N,
    input  logic       iWR,
    input  logic [4:0] iWADDR,
    input  logic [7:0] iWDATA,
    input  logic       iREFRESH,
    output logic [7:0] oDATA,
    output logic       oRS,
    output logic       oStart,
    input  logic       iDone,
    output logic       oBusy
);
    localparam int CW = $clog2(DLY_CYCLES + 1);
    localparam logic [CW-1:0] DLY_LAST = CW'(DLY_CYCLES - 1);
    localparam logic [5:0] L1_END = 6'(4 + COLS);
    localparam logic [5:0] L2_CMD = 6'(5 + COLS);
    localparam logic [5:0] LAST   = (NUM_LINES == 2) ? 6'(5 + 2 * COLS) : 6'(4 + COLS);
    localparam logic [5:0] REDRAW_START = 6'd4;
    localparam logic [4:0] COLS_L = 5'(COLS);

    typedef enum logic [2:0] {S_INIT, S_SEND, S_WAIT_DONE, S_DELAY, S_NEXT, S_IDLE} state_t;

    state_t        r_state, w_next;
    logic [5:0]    r_idx;
    logic [CW-1:0] r_cnt;
    logic          r_pend;
    logic [7:0]    r_buf [0:31];

    logic       w_wr_ok, w_pend_set, w_launch, w_load, w_start_clr;
    logic [3:0] w_c1, w_c2;
    logic [7:0] w_item_data;
    logic       w_item_rs;

    assign w_wr_ok = iWR && ({1'b0, iWADDR[3:0]} < COLS_L) && (!iWADDR[4] || (NUM_LINES == 2));
`ifdef LCD_AUTO_REFRESH_EN
    assign w_pend_set = iREFRESH | w_wr_ok;
`else
    assign w_pend_set = iREFRESH;
`endif
    assign oBusy = (r_state != S_IDLE);

    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            for (int i = 0; i < 32; i++) r_buf[i] <= 8'h20;
        end else if (w_wr_ok) begin
            r_buf[iWADDR] <= iWDATA;
        end
    end

    // Item index layout: 0-3 init commands, 4 = 80h, then line-1 chars, C0h, line-2 chars.
    assign w_c1 = 4'(r_idx - 6'd5);
    assign w_c2 = 4'(r_idx - L2_CMD - 6'd1);

    always_comb begin
        w_item_rs   = 1'b0;
        w_item_data = 8'h00;
        case (r_idx)
            6'd0: w_item_data = 8'h38;
            6'd1: w_item_data = 8'h0C;
            6'd2: w_item_data = 8'h01;
            6'd3: w_item_data = 8'h06;
            6'd4: w_item_data = 8'h80;
            default: begin
                if (r_idx <= L1_END) begin
                    w_item_rs   = 1'b1;
                    w_item_data = r_buf[{1'b0, w_c1}];
                end else if (r_idx == L2_CMD) begin
                    w_item_data = 8'hC0;
                end else begin
                    w_item_rs   = 1'b1;
                    w_item_data = r_buf[{1'b1, w_c2}];
                end
            end
        endcase
    end

    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) r_state <= S_INIT;
        else         r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_INIT:      w_next = S_SEND;
            S_SEND:      w_next = S_WAIT_DONE;
            S_WAIT_DONE: if (iDone) w_next = S_DELAY;
            S_DELAY:     if (r_cnt == DLY_LAST) w_next = S_NEXT;
            S_NEXT:      w_next = (r_idx != LAST || w_launch) ? S_SEND : S_IDLE;
            S_IDLE:      if (w_launch) w_next = S_SEND;
            default:     w_next = S_INIT;
        endcase
    end

    always_comb begin
        w_load      = (r_state == S_SEND);
        w_start_clr = (r_state == S_WAIT_DONE) && iDone;
        w_launch    = (r_pend || w_pend_set) &&
                      ((r_state == S_IDLE) || (r_state == S_NEXT && r_idx == LAST));
    end

    // Output bytes are captured in SEND, so a same-cycle buffer write only affects later reads.
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            oDATA  <= 8'h00;
            oRS    <= 1'b0;
            oStart <= 1'b0;
            r_idx  <= 6'd0;
            r_cnt  <= '0;
            r_pend <= 1'b0;
        end else begin
            if (w_load) begin
                oDATA  <= w_item_data;
                oRS    <= w_item_rs;
                oStart <= 1'b1;
            end
            if (w_start_clr) oStart <= 1'b0;
            if (w_start_clr)             r_cnt <= '0;
            else if (r_state == S_DELAY) r_cnt <= r_cnt + CW'(1);
            if (r_state == S_NEXT) r_idx <= (r_idx == LAST) ? REDRAW_START : r_idx + 6'd1;
            r_pend <= w_launch ? 1'b0 : (r_pend | w_pend_set);
        end
    end
endmodule
